// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM states, default sizes and the
// priority-encoded decision taken each cycle in RUN.
package gcd_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One outcome per RUN cycle, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    DEC_ZERO   = 3'd0,  // both operands zero
    DEC_A_ZERO = 3'd1,  // A zero, result is B
    DEC_B_ZERO = 3'd2,  // B zero, result is A
    DEC_EQ     = 3'd3,  // A == B, result is A
    DEC_A_GT   = 3'd4,  // A > B, A <= A - B
    DEC_B_GT   = 3'd5   // A < B, B <= B - A
  } run_dec_t;

  function automatic run_dec_t run_decide(input logic a_zero, input logic b_zero,
                                          input logic eq, input logic gt);
    run_dec_t d;
    if (a_zero && b_zero) d = DEC_ZERO;
    else if (a_zero)      d = DEC_A_ZERO;
    else if (b_zero)      d = DEC_B_ZERO;
    else if (eq)          d = DEC_EQ;
    else if (gt)          d = DEC_A_GT;
    else                  d = DEC_B_GT;
    return d;
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparator and a single shared subtractor for the GCD
// engine. The subtractor always takes larger minus smaller, so it cannot wrap.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub_en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             a_zero,
  output logic             b_zero,
  output logic             eq,
  output logic             gt
);

  logic [WIDTH-1:0] diff;

  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign eq     = (a_q == b_q);
  assign gt     = (a_q > b_q);
  assign diff   = gt ? (a_q - b_q) : (b_q - a_q);

  // Load a fresh operand pair, or replace the larger operand by the difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (sub_en) begin
      if (gt) a_q <= diff;
      else    b_q <= diff;
    end
  end

endmodule

// File: rtl/gcd_core.sv
// Subtractive-Euclid GCD engine, one compare-and-subtract per cycle.
// Optional build macro GCD_ITER_COUNT_EN adds the iter_cnt subtract-step
// counter (saturating at 2^CNT_W-1).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_ready is high only in IDLE; a pair offered while
// busy waits until in_ready returns. Output side: out_valid stays high and
// gcd_out/zero_flag stay stable until out_ready is seen; the engine then
// returns to IDLE, so a new pair is taken no earlier than the next cycle.
module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_flag,
  output state_t           dbg_state,
  output logic             busy
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [CNT_W-1:0] iter_cnt
`endif
);

  state_t           state;
  run_dec_t         dec;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             a_zero;
  logic             b_zero;
  logic             eq;
  logic             gt;
  logic             load;
  logic             sub_en;

  assign dec       = run_decide(a_zero, b_zero, eq, gt);
  assign load      = (state == IDLE) && in_valid;
  assign sub_en    = (state == RUN) && ((dec == DEC_A_GT) || (dec == DEC_B_GT));
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .sub_en (sub_en),
    .a_in   (a_in),
    .b_in   (b_in),
    .a_q    (a_q),
    .b_q    (b_q),
    .a_zero (a_zero),
    .b_zero (b_zero),
    .eq     (eq),
    .gt     (gt)
  );

  // Control FSM with registered result, zero flag and output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gcd_out   <= '0;
      out_valid <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= RUN;
        end
        RUN: begin
          case (dec)
            DEC_ZERO: begin
              gcd_out   <= '0;
              zero_flag <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end
            DEC_A_ZERO: begin
              gcd_out   <= b_q;
              zero_flag <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
            DEC_B_ZERO, DEC_EQ: begin
              gcd_out   <= a_q;
              zero_flag <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
            default: state <= RUN;
          endcase
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            zero_flag <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_ITER_COUNT_EN
  // Count subtract steps of the current operation, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst || load) iter_cnt <= '0;
    else if (sub_en && (iter_cnt != '1)) iter_cnt <= iter_cnt + 1'b1;
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_gcd_core.sv
// Self-checking bench for gcd_core: directed corner cases followed by 500
// randomized operations scored against a modulo-Euclid reference model.
module tb_gcd_core;
  import gcd_pkg::*;

  localparam int W  = 16;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] gcd_out;
  logic         zero_flag;
  state_t       dbg_state;
  logic         busy;
`ifdef GCD_ITER_COUNT_EN
  logic [CW-1:0] iter_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  gcd_core #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .zero_flag (zero_flag),
    .dbg_state (dbg_state),
    .busy      (busy)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_cnt  (iter_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: modulo Euclid. The subtractive engine takes sum(quotients)-1
  // subtract steps, since the final quotient ends on an equality, not zero.
  task automatic ref_gcd(input int unsigned a, input int unsigned b,
                         output int unsigned g, output int unsigned steps);
    int unsigned x, y, t, s;
    if (a == 0 || b == 0) begin
      g = a + b;
      steps = 0;
    end else begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        s += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x;
      steps = s - 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Driver: issue one pair, optionally toggle in_valid noise while busy,
  // then hold off the result for 'hold' cycles before accepting it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit noise);
    int unsigned g, steps;
    int lat;
    logic [W-1:0] held;
    ref_gcd(int'(a), int'(b), g, steps);
    exp_q.push_back(W'(g));
    check("in_ready_idle", in_ready, 1);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat <= int'(steps) + 8) begin
      check("in_ready_busy", in_ready, 0);
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      check("timeout", 0, 1);
      exp_q.delete();
      do_reset();
      return;
    end
    check("latency", lat, steps + 1);
    check("gcd_out", gcd_out, exp_q.pop_front());
    check("zero_flag", zero_flag, (a == 0 && b == 0));
`ifdef GCD_ITER_COUNT_EN
    check("iter_cnt", iter_cnt, (steps > 15) ? 15 : steps);
`endif
    held = gcd_out;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_gcd", gcd_out, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("acc_in_ready", in_ready, 1);
    check("acc_out_valid", out_valid, 0);
    check("acc_busy", busy, 0);
    check("acc_zero_flag", zero_flag, 0);
    check("acc_gcd_held", gcd_out, held);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rg;
    int unsigned g, steps;
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_gcd", gcd_out, 0);
    check("rst_zero_flag", zero_flag, 0);
    check("rst_state", dbg_state, IDLE);
`ifdef GCD_ITER_COUNT_EN
    check("rst_iter_cnt", iter_cnt, 0);
`endif

    do_op(16'd12, 16'd8, 0, 1'b0);
    do_op(16'd0, 16'd0, 0, 1'b0);
    do_op(16'd0, 16'd9, 0, 1'b0);
    do_op(16'd9, 16'd0, 0, 1'b0);
    do_op(16'd255, 16'd1, 0, 1'b1);
    do_op(16'd35, 16'd14, 10, 1'b0);
    do_op(16'd100, 16'd1, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0);

    // Reset in the middle of a long operation discards it.
    a_in = 16'd1000; b_in = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, IDLE);
    @(posedge clk); #1;
    check("abort_still_idle", out_valid, 0);
    do_op(16'd21, 16'd6, 0, 1'b0);

    // Randomized back-to-back operations with bounded step counts.
    for (int i = 0; i < 500; i++) begin
      for (int t = 0; t < 40; t++) begin
        case ($urandom_range(0, 3))
          0: begin ra = W'($urandom_range(0, 255)); rb = W'($urandom_range(0, 255)); end
          1: begin ra = W'($urandom); rb = W'($urandom); end
          2: begin ra = W'($urandom); rb = ($urandom_range(0, 1) != 0) ? ra : '0; end
          default: begin
            rg = W'($urandom_range(1, 300));
            ra = rg * W'($urandom_range(0, 200));
            rb = rg * W'($urandom_range(0, 200));
          end
        endcase
        ref_gcd(int'(ra), int'(rb), g, steps);
        if (steps <= 100) break;
        ra = W'($urandom_range(1, 60));
        rb = W'($urandom_range(1, 60));
      end
      do_op(ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
